uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one management-SoC UART transmitter (byte serializer) among NUM_REQ byte-stream
//   requesters: CPU console, debug monitor, housekeeping.
//   Grants are round-robin and message-atomic. A grant holds until the requester's last
//   byte, or until a burst cap forces release. Sits between the requesters and the
//   serializer that drives ser_tx.
// PARAMETERS
//   NUM_REQ    3   number of requesters (2..8)
//   DATA_W     8   byte width presented to the serializer
//   MAX_BURST  16  max bytes per grant before forced release; 0 = unlimited
// PORTS
//   core_clk    in   1                 single clock
//   core_rst    in   1                 reset, synchronous, active-high
//   enable      in   1                 0: no new grants; current message completes
//   req_valid   in   NUM_REQ           per-requester byte valid
//   req_data    in   NUM_REQ*DATA_W    requester i occupies bits [i*DATA_W +: DATA_W]
//   req_last    in   NUM_REQ           byte is last of message
//   req_ready   out  NUM_REQ           per-requester accept
//   tx_valid    out  1                 byte to serializer valid
//   tx_data     out  DATA_W            byte to serializer
//   tx_ready    in   1                 serializer accepts (idle, not shifting)
//   grant_id    out  clog2(NUM_REQ)    current owner; valid while busy
//   busy        out  1                 grant held
//   preempt     out  1                 one-cycle pulse on forced release at MAX_BURST
// BEHAVIOUR
//   Reset values: state=IDLE, rr_ptr=0, burst_cnt=0, grant_id=0.
//     Outputs busy, preempt, tx_valid, req_ready all 0.
//   States: IDLE, GRANT.
//   IDLE:
//     - if enable and any req_valid: choose first valid index at or after rr_ptr (wrapping).
//     - register grant_id; go to GRANT next cycle (1 cycle arbitration latency).
//     - busy rises with GRANT.
//   GRANT datapath (no register stage; zero added latency):
//     - tx_valid = req_valid[grant_id]; tx_data = req_data[grant_id].
//     - req_ready[grant_id] = tx_ready; all other req_ready = 0.
//   Transfer = tx_valid & tx_ready. On each transfer burst_cnt increments (width clog2(MAX_BURST+1)).
//   Release happens on the transfer cycle if either holds:
//     (a) req_last[grant_id]=1, or
//     (b) MAX_BURST!=0 and burst_cnt==MAX_BURST-1.
//   (b) without (a) also pulses preempt for that cycle.
//   On release:
//     - next state IDLE; burst_cnt=0; rr_ptr=(grant_id+1) mod NUM_REQ.
//     - IDLE always takes one cycle, so back-to-back messages carry a 1-cycle bubble.
//   Owner drops req_valid mid-message: grant is kept (no timeout); tx_valid follows it low.
//   enable deasserted in GRANT: no effect until release, then remain IDLE.
//   req_valid/req_data/req_last of non-owners are ignored and need not be stable.
//   MAX_BURST=1: every byte releases; preempt pulses only when req_last=0.
//   Reset mid-message: immediate return to reset values. The partial message is abandoned;
//     the serializer is responsible for its own reset.
//   Protocol assertion (sim only): owner holds req_data/req_last stable while valid & !ready.
// STRUCTURE
//   Package uart_arb_pkg:
//     - state enum {IDLE, GRANT}
//     - function id_w(n) = clog2(n), minimum 1
//     - DATA_W default constant
//   Sub-module rr_pick:
//     - combinational first-set-at-or-after-pointer search over NUM_REQ bits.
//     - outputs index + found.
//   Top: state register, burst counter, output mux.
// TESTING
//   1. Single req0, 4-byte message 0x41..0x44, tx_ready=1:
//      grant_id=0 one cycle after req; 4 transfers in 4 consecutive cycles; busy drops after 0x44.
//   2. req0,req1,req2 all pending 2-byte messages, rr_ptr=0:
//      serialized order 0,1,2; 1-cycle bubble between; rr_ptr ends at 0.
//   3. req1 sends 20 bytes, no last, MAX_BURST=16:
//      preempt pulses on byte 16; req2 pending gets grant next; req1 regains after req2 finishes.
//   4. tx_ready toggling 1-of-4 cycles during a 3-byte message:
//      no byte lost or duplicated; req_ready mirrors tx_ready only for owner.
//   5. enable=0 mid-message of req0 with req1 pending:
//      req0 completes, state stays IDLE; req1 granted 1 cycle after enable=1.
//   6. core_rst asserted on byte 2 of 4:
//      next cycle busy=0, tx_valid=0, req_ready=0, grant_id=0, rr_ptr=0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding,
// index-width helper and the default byte width.
package uart_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DATA_W_DEF = 8;

  // Index width for n items, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the UART serializer.
// Handshake: a byte moves on any cycle where valid and ready are both high; the
// source holds data/last stable while valid is high and ready is low.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_valid;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_ready;

  // master: the surrounding system (requesters plus serializer)
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );

  // slave: the arbiter
  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin search: first set bit of req at or after ptr, wrapping around N.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest hit is the one that sticks.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, k)]) begin
        idx   = wrap_add(ptr, k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-atomic arbiter sharing one UART serializer among NUM_REQ
// byte-stream requesters, with an optional per-grant burst cap.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 16,
  localparam int IW       = id_w(NUM_REQ)
) (
  input  logic                core_clk,
  input  logic                core_rst,
  input  logic                enable,
  uart_tx_arbiter_if.slave    bus,
  output logic [IW-1:0]       grant_id,
  output logic                busy,
  output logic                preempt,
  output arb_state_t          state_dbg,
  output logic [IW-1:0]       rr_ptr_dbg
);

  localparam int CNT_W = id_w(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CAP_M1 = CNT_W'(MAX_BURST - 1);

  arb_state_t        state;
  logic [IW-1:0]     rr_ptr;
  logic [CNT_W-1:0]  burst_cnt;

  logic [IW-1:0]     pick_idx;
  logic              pick_found;
  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic              own_valid;
  logic              own_last;
  logic [DATA_W-1:0] own_data;
  logic [NUM_REQ-1:0] ready_vec;
  logic              xfer;
  logic              cap_hit;
  logic              release_now;
  logic [IW-1:0]     next_ptr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Owner's stream goes straight through to the serializer with no register stage.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    ready_vec = '0;
    if (state == GRANT) begin
      own_valid           = bus.req_valid[grant_id];
      own_last            = bus.req_last[grant_id];
      own_data            = data_arr[grant_id];
      ready_vec[grant_id] = bus.tx_ready;
    end
  end

  assign bus.tx_valid  = own_valid;
  assign bus.tx_data   = own_data;
  assign bus.req_ready = ready_vec;

  assign xfer        = own_valid & bus.tx_ready;
  assign cap_hit     = (MAX_BURST != 0) && (burst_cnt == CAP_M1);
  assign release_now = xfer & (own_last | cap_hit);
  assign preempt     = xfer & cap_hit & ~own_last;
  assign next_ptr    = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  assign busy       = (state == GRANT);
  assign state_dbg  = state;
  assign rr_ptr_dbg = rr_ptr;

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      grant_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && pick_found) begin
            grant_id <= pick_idx;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            state     <= IDLE;
            burst_cnt <= '0;
            rr_ptr    <= next_ptr;
          end else if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Owner must not change a byte the serializer has not yet taken.
  hold_stable: assert property (@(posedge core_clk) disable iff (core_rst)
    (state == GRANT && own_valid && !bus.tx_ready) |=>
      (!own_valid || (own_data == $past(own_data) && own_last == $past(own_last))));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte sources, a transfer
// monitor against an expected queue, and one task per scenario.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NR = 3;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int IW = 2;

  logic          clk;
  logic          rst;
  logic          en;
  logic [IW-1:0] grant_id;
  logic [IW-1:0] rr_ptr_dbg;
  logic          busy;
  logic          preempt;
  arb_state_t    state_dbg;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .core_clk   (clk),
    .core_rst   (rst),
    .enable     (en),
    .bus        (bus),
    .grant_id   (grant_id),
    .busy       (busy),
    .preempt    (preempt),
    .state_dbg  (state_dbg),
    .rr_ptr_dbg (rr_ptr_dbg)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int xfer_count = 0;
  logic [10:0] exp_q[$];
  int          xfer_cyc[$];
  logic [8:0]  src_q [NR][$];
  logic [NR-1:0] fire;
  bit ready_mode;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 20000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b1;
    ready_mode = 1'b0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    xfer_cyc.delete();
    fire = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_msg(input int r, input int n, input logic [7:0] base, input bit with_last);
    for (int k = 0; k < n; k++)
      src_q[r].push_back({(with_last && k == n - 1), 8'(base + k)});
  endtask

  task automatic add_exp(input int r, input logic [7:0] d, input bit pre);
    exp_q.push_back({pre, 2'(r), d});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0 || busy) begin
      bad++;
      $display("FAIL %s_timeout: got pending=%0d busy=%0b want pending=0 busy=0", name, exp_q.size(), busy);
    end
  endtask

  // Sources present their queue heads at negedge; the monitor then predicts
  // and scores the transfer that the next posedge will perform.
  initial begin
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] d;
    logic [10:0]      e;
    logic [10:0]      o;
    logic [NR-1:0]    exp_rdy;
    fire = '0;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++)
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() > 0) begin
          v[i] = 1'b1;
          d[i*DW +: DW] = src_q[i][0][7:0];
          l[i] = src_q[i][0][8];
        end else begin
          v[i] = 1'b0;
          d[i*DW +: DW] = 8'($urandom_range(0, 255));
          l[i] = 1'($urandom_range(0, 1));
        end
      end
      bus.req_valid = v;
      bus.req_data = d;
      bus.req_last = l;
      bus.tx_ready = ready_mode ? ((cyc % 4) == 0) : 1'b1;
      #1;
      fire = bus.req_valid & bus.req_ready & {NR{!rst}};
      if (!rst) begin
        exp_rdy = busy ? (NR'(bus.tx_ready) << grant_id) : '0;
        total++;
        if (bus.req_ready !== exp_rdy) begin
          bad++;
          $display("FAIL ready_map: got %b want %b", bus.req_ready, exp_rdy);
        end
        if (bus.tx_valid && bus.tx_ready) begin
          total++;
          o = {preempt, grant_id, bus.tx_data};
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_xfer: got pre=%0b id=%0d data=%h want none", o[10], o[9:8], o[7:0]);
          end else begin
            e = exp_q.pop_front();
            if (o !== e) begin
              bad++;
              $display("FAIL xfer: got pre=%0b id=%0d data=%h want pre=%0b id=%0d data=%h",
                       o[10], o[9:8], o[7:0], e[10], e[9:8], e[7:0]);
            end
          end
          xfer_count++;
          xfer_cyc.push_back(cyc);
        end else begin
          total++;
          if (preempt !== 1'b0) begin
            bad++;
            $display("FAIL idle_preempt: got %b want 0", preempt);
          end
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (preempt !== 1'b0) begin bad++; $display("FAIL rst_preempt: got %b want 0", preempt); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid: got %b want 0", bus.tx_valid); end
    total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL rst_req_ready: got %b want 000", bus.req_ready); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    total++; if (rr_ptr_dbg !== 2'd0) begin bad++; $display("FAIL rst_rr_ptr: got %0d want 0", rr_ptr_dbg); end
    total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want IDLE", state_dbg); end
  endtask

  task automatic test_single_msg();
    do_reset();
    push_msg(0, 4, 8'h41, 1'b1);
    for (int k = 0; k < 4; k++) add_exp(0, 8'(8'h41 + k), 1'b0);
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_grant_busy: got %b want 1", busy); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL t1_grant_id: got %0d want 0", grant_id); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      total++;
      if (busy !== (k < 3)) begin bad++; $display("FAIL t1_busy_%0d: got %b want %b", k, busy, (k < 3)); end
    end
    total++;
    if (xfer_cyc.size() != 4 || exp_q.size() != 0) begin
      bad++; $display("FAIL t1_count: got %0d xfers want 4", xfer_cyc.size());
    end else if (xfer_cyc[3] - xfer_cyc[0] != 3) begin
      bad++; $display("FAIL t1_consecutive: got span %0d want 3", xfer_cyc[3] - xfer_cyc[0]);
    end
  endtask

  task automatic test_round_robin();
    int want_gap[5] = '{1, 2, 1, 2, 1};
    do_reset();
    push_msg(0, 2, 8'h20, 1'b1);
    push_msg(1, 2, 8'h30, 1'b1);
    push_msg(2, 2, 8'h40, 1'b1);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 2; k++) add_exp(r, 8'(8'h20 + 8'h10 * r + k), 1'b0);
    wait_idle("t2", 40);
    total++;
    if (xfer_cyc.size() != 6) begin
      bad++; $display("FAIL t2_count: got %0d want 6", xfer_cyc.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (xfer_cyc[k+1] - xfer_cyc[k] != want_gap[k]) begin
          bad++; $display("FAIL t2_gap_%0d: got %0d want %0d", k, xfer_cyc[k+1] - xfer_cyc[k], want_gap[k]);
        end
      end
    end
    total++; if (rr_ptr_dbg !== 2'd0) begin bad++; $display("FAIL t2_rr_ptr: got %0d want 0", rr_ptr_dbg); end
  endtask

  task automatic test_burst_cap();
    do_reset();
    push_msg(1, 20, 8'h10, 1'b1);
    push_msg(2, 2, 8'hA0, 1'b1);
    for (int k = 0; k < 16; k++) add_exp(1, 8'(8'h10 + k), (k == 15));
    add_exp(2, 8'hA0, 1'b0);
    add_exp(2, 8'hA1, 1'b0);
    for (int k = 16; k < 20; k++) add_exp(1, 8'(8'h10 + k), 1'b0);
    wait_idle("t3", 80);
    total++; if (xfer_cyc.size() != 22) begin bad++; $display("FAIL t3_count: got %0d want 22", xfer_cyc.size()); end
    total++; if (rr_ptr_dbg !== 2'd2) begin bad++; $display("FAIL t3_rr_ptr: got %0d want 2", rr_ptr_dbg); end
  endtask

  task automatic test_ready_toggle();
    int ok = 1;
    do_reset();
    ready_mode = 1'b1;
    push_msg(0, 3, 8'h51, 1'b1);
    push_msg(1, 1, 8'h61, 1'b1);
    for (int k = 0; k < 3; k++) add_exp(0, 8'(8'h51 + k), 1'b0);
    add_exp(1, 8'h61, 1'b0);
    wait_idle("t4", 80);
    total++; if (xfer_cyc.size() != 4) begin bad++; $display("FAIL t4_count: got %0d want 4", xfer_cyc.size()); end
    foreach (xfer_cyc[k]) if (xfer_cyc[k] % 4 != 0) ok = 0;
    total++; if (ok != 1) begin bad++; $display("FAIL t4_xfer_on_ready: got %0d want 1", ok); end
    ready_mode = 1'b0;
  endtask

  task automatic test_enable_gate();
    int base;
    int n;
    do_reset();
    push_msg(0, 4, 8'h71, 1'b1);
    push_msg(1, 2, 8'h81, 1'b1);
    for (int k = 0; k < 4; k++) add_exp(0, 8'(8'h71 + k), 1'b0);
    add_exp(1, 8'h81, 1'b0);
    add_exp(1, 8'h82, 1'b0);
    base = xfer_count;
    n = 0;
    while (xfer_count < base + 1 && n < 20) begin @(posedge clk); #1; n++; end
    en = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (xfer_count !== base + 4) begin bad++; $display("FAIL t5_owner_done: got %0d want %0d", xfer_count - base, 4); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || state_dbg !== IDLE) begin
        bad++; $display("FAIL t5_hold_idle_%0d: got busy=%b state=%0d want busy=0 state=IDLE", k, busy, state_dbg);
      end
    end
    en = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t5_regrant_busy: got %b want 1", busy); end
    total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL t5_regrant_id: got %0d want 1", grant_id); end
    wait_idle("t5", 20);
  endtask

  task automatic test_reset_mid_msg();
    int base;
    int n;
    do_reset();
    push_msg(1, 1, 8'hB0, 1'b1);
    add_exp(1, 8'hB0, 1'b0);
    wait_idle("t6a", 20);
    total++; if (rr_ptr_dbg !== 2'd2) begin bad++; $display("FAIL t6_pre_rr_ptr: got %0d want 2", rr_ptr_dbg); end
    push_msg(2, 4, 8'h91, 1'b1);
    add_exp(2, 8'h91, 1'b0);
    base = xfer_count;
    n = 0;
    while (xfer_count < base + 1 && n < 20) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_busy: got %b want 0", busy); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL t6_tx_valid: got %b want 0", bus.tx_valid); end
    total++; if (bus.req_ready !== 3'b000) begin bad++; $display("FAIL t6_req_ready: got %b want 000", bus.req_ready); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL t6_grant_id: got %0d want 0", grant_id); end
    total++; if (rr_ptr_dbg !== 2'd0) begin bad++; $display("FAIL t6_rr_ptr: got %0d want 0", rr_ptr_dbg); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t6_first_byte: got pending=%0d want 0", exp_q.size()); end
    for (int i = 0; i < NR; i++) src_q[i].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_msg(0, 1, 8'hC0, 1'b1);
    add_exp(0, 8'hC0, 1'b0);
    wait_idle("t6b", 20);
    total++; if (rr_ptr_dbg !== 2'd1) begin bad++; $display("FAIL t6_post_rr_ptr: got %0d want 1", rr_ptr_dbg); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    en = 1'b1;
    ready_mode = 1'b0;
    test_reset();
    test_single_msg();
    test_round_robin();
    test_burst_cap();
    test_ready_toggle();
    test_enable_gate();
    test_reset_mid_msg();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
